// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: valid/ready commands in, pipelined NONSEQ transfers out, one response per command.
// Define AHB_MASTER_ERR_EN to honour HRESP (two-cycle error response cancels the queued address phase).
module ahb_lite_master #(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [1:0]    cmd_size,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [1:0]    HTRANS,
  output logic [31:0]   HADDR,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic        addr_pending;
  logic [31:0] addr_wdata;
  logic        data_pending;
  logic        data_write;
  logic [1:0]  data_size;
  logic [1:0]  data_lo;
  logic        accept;
  logic        err_first;
  logic [1:0]  cmd_sz;
  logic [31:0] cmd_addr_ext;

  function automatic logic [31:0] align_addr(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return a;
      2'd1:    return {a[31:1], 1'b0};
      default: return {a[31:2], 2'b00};
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] sz, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [31:0] s;
    s = d >> {lo, 3'b000};
    case (sz)
      2'd0:    return {24'h0, s[7:0]};
      2'd1:    return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Size 3 is treated as a word everywhere, including HSIZE.
  assign cmd_sz       = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
  assign cmd_addr_ext = 32'(cmd_addr);

`ifdef AHB_MASTER_ERR_EN
  logic cancel_pend;
  logic cancel_rsp;
  assign err_first = data_pending && HRESP && !HREADY;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign err_first    = 1'b0;
`endif

  assign cmd_ready = (!addr_pending || HREADY) && !err_first;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_pending <= 1'b0;
      addr_wdata   <= 32'h0;
      data_pending <= 1'b0;
      data_write   <= 1'b0;
      data_size    <= 2'd0;
      data_lo      <= 2'd0;
      HTRANS       <= TRANS_IDLE;
      HADDR        <= 32'h0;
      HWRITE       <= 1'b0;
      HSIZE        <= 3'd0;
      HWDATA       <= 32'h0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
`ifdef AHB_MASTER_ERR_EN
      cancel_pend  <= 1'b0;
      cancel_rsp   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;

      // Data slot: completes and refills only on HREADY.
      if (HREADY) begin
        if (data_pending) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= data_write ? 32'h0 : extract(data_size, data_lo, HRDATA);
`ifdef AHB_MASTER_ERR_EN
          rsp_err   <= HRESP;
`else
          rsp_err   <= 1'b0;
`endif
        end
        data_pending <= addr_pending;
        if (addr_pending) begin
          data_write <= HWRITE;
          data_size  <= HSIZE[1:0];
          data_lo    <= HADDR[1:0];
          HWDATA     <= replicate(HSIZE[1:0], addr_wdata);
        end
      end

`ifdef AHB_MASTER_ERR_EN
      // The cancelled command answers one cycle after the errored transfer.
      if (err_first && addr_pending) cancel_pend <= 1'b1;
      if (HREADY && data_pending && cancel_pend) begin
        cancel_pend <= 1'b0;
        cancel_rsp  <= 1'b1;
      end
      if (cancel_rsp) begin
        cancel_rsp <= 1'b0;
        rsp_valid  <= 1'b1;
        rsp_err    <= 1'b1;
        rsp_rdata  <= 32'h0;
      end
`endif

      // Address slot.
      if (accept) begin
        addr_pending <= 1'b1;
        addr_wdata   <= cmd_wdata;
        HTRANS       <= TRANS_NONSEQ;
        HADDR        <= align_addr(cmd_sz, cmd_addr_ext);
        HWRITE       <= cmd_write;
        HSIZE        <= {1'b0, cmd_sz};
      end else if (HREADY || err_first) begin
        addr_pending <= 1'b0;
        HTRANS       <= TRANS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master against a small behavioural AHB SRAM slave with wait/error injection.
// The error-response scenario runs only when AHB_MASTER_ERR_EN is defined.
module tb_ahb_lite_master;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;

  int n_chk = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.AW(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  // Behavioural slave
  logic [31:0] mem [0:1023];
  logic        dp_valid, dp_write;
  logic [1:0]  dp_size;
  logic [31:0] dp_addr;
  int          ws_left;
  logic [1:0]  err_phase;
  int          wait_req = 0;
  logic        err_req = 1'b0;

  function automatic bit lane_en(input logic [1:0] sz, input logic [1:0] lo, input int b);
    if (sz == 2'd2) return 1'b1;
    if (sz == 2'd1) return (b / 2) == int'(lo[1]);
    return b == int'(lo);
  endfunction

  assign HREADY = (ws_left == 0) && (err_phase != 2'd1);
  assign HRESP  = (err_phase != 2'd0);
  assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[11:2]] : 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_size   <= 2'd0;
      dp_addr   <= 32'h0;
      ws_left   <= 0;
      err_phase <= 2'd0;
    end else if (HREADY) begin
      if (dp_valid && dp_write && err_phase == 2'd0)
        for (int b = 0; b < 4; b++)
          if (lane_en(dp_size, dp_addr[1:0], b))
            mem[dp_addr[11:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      dp_valid  <= HTRANS[1];
      dp_addr   <= HADDR;
      dp_write  <= HWRITE;
      dp_size   <= HSIZE[1:0];
      ws_left   <= (HTRANS[1] && !HWRITE) ? wait_req : 0;
      err_phase <= (HTRANS[1] && err_req) ? 2'd1 : 2'd0;
    end else begin
      if (ws_left > 0) ws_left <= ws_left - 1;
      if (err_phase == 2'd1) err_phase <= 2'd2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_cmd(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output logic [31:0] haddr_seen,
                        output logic [2:0] hsize_seen, output logic [31:0] hwdata_seen);
    int guard;
    bit got;
    cmd_write = wr; cmd_size = sz; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin tick(); guard++; end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    haddr_seen = HADDR; hsize_seen = HSIZE;
    cmd_valid = 1'b0;
    lat = 0; rd = 32'h0; err = 1'b0; hwdata_seen = 32'h0; got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) hwdata_seen = HWDATA;
      if (rsp_valid) begin rd = rsp_rdata; err = rsp_err; got = 1'b1; end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, ha, hw;
    logic [2:0]  hs;
    logic        er;
    int          lat;
    bit          seen;

    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0;
    repeat (3) tick();
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    HRESET = 1'b0;
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'h1);

    // Word write then read back
    do_cmd(1'b1, 2'd2, 32'h0, 32'h44332211, rd, er, lat, ha, hs, hw);
    chk("wr0_lat", 32'(lat), 32'd2);
    chk("wr0_hwdata", hw, 32'h44332211);
    chk("wr0_rsp", {rd[30:0], er}, 32'h0);
    do_cmd(1'b0, 2'd2, 32'h0, 32'h0, rd, er, lat, ha, hs, hw);
    chk("rd0_lat", 32'(lat), 32'd2);
    chk("rd0_data", rd, 32'h44332211);
    chk("rd0_err", 32'(er), 32'h0);

    // Sub-word reads
    do_cmd(1'b0, 2'd1, 32'h2, 32'h0, rd, er, lat, ha, hs, hw);
    chk("rdh2_hsize", 32'(hs), 32'd1);
    chk("rdh2_data", rd, 32'h00004433);
    do_cmd(1'b0, 2'd0, 32'h1, 32'h0, rd, er, lat, ha, hs, hw);
    chk("rdb1_haddr", ha, 32'h1);
    chk("rdb1_data", rd, 32'h00000022);

    // Byte write with lane replication, misaligned half read, word read
    do_cmd(1'b1, 2'd0, 32'h3, 32'h000000AB, rd, er, lat, ha, hs, hw);
    chk("wrb3_hwdata", hw, 32'hABABABAB);
    chk("wrb3_hsize", 32'(hs), 32'd0);
    do_cmd(1'b0, 2'd1, 32'h3, 32'h0, rd, er, lat, ha, hs, hw);
    chk("rdh3_haddr", ha, 32'h2);
    chk("rdh3_data", rd, 32'h0000AB33);
    do_cmd(1'b0, 2'd3, 32'h0, 32'h0, rd, er, lat, ha, hs, hw);
    chk("rdw_size3_hsize", 32'(hs), 32'd2);
    chk("rdw_data", rd, 32'hAB332211);

    // Back-to-back write then read at 0xA00
    cmd_write = 1'b1; cmd_size = 2'd2; cmd_addr = 32'hA00; cmd_wdata = 32'hDEADBEEF;
    cmd_valid = 1'b1;
    tick();
    chk("b2b_wr_htrans", 32'(HTRANS), 32'h2);
    chk("b2b_wr_haddr", HADDR, 32'hA00);
    chk("b2b_wr_hwrite", 32'(HWRITE), 32'h1);
    cmd_write = 1'b0;
    chk("b2b_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk("b2b_rd_htrans", 32'(HTRANS), 32'h2);
    chk("b2b_rd_hwrite", 32'(HWRITE), 32'h0);
    cmd_valid = 1'b0;
    tick();
    chk("b2b_rsp1", {rsp_valid, rsp_err}, 32'h2);
    chk("b2b_idle", 32'(HTRANS), 32'h0);
    tick();
    chk("b2b_rsp2", 32'(rsp_valid), 32'h1);
    chk("b2b_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("b2b_quiet", 32'(rsp_valid), 32'h0);

    // Three wait states on a read, second read queued in the address phase
    wait_req = 3;
    cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'hA00; cmd_valid = 1'b1;
    tick();
    cmd_addr = 32'h0;
    tick();
    wait_req = 0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_htrans", 32'(HTRANS), 32'h2);
      chk("ws_haddr", HADDR, 32'h0);
      chk("ws_ready", 32'(cmd_ready), 32'h0);
      chk("ws_norsp", 32'(rsp_valid), 32'h0);
      tick();
    end
    chk("ws_norsp_end", 32'(rsp_valid), 32'h0);
    tick();
    chk("ws_rspA", 32'(rsp_valid), 32'h1);
    chk("ws_rdataA", rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("ws_rspB", 32'(rsp_valid), 32'h1);
    chk("ws_rdataB", rsp_rdata, 32'hAB332211);

    // Reset during data phase of a write
    cmd_write = 1'b1; cmd_size = 2'd2; cmd_addr = 32'h10; cmd_wdata = 32'h12345678;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rstm_hwdata", HWDATA, 32'h12345678);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("rstm_htrans", 32'(HTRANS), 32'h0);
    chk("rstm_hwdata0", HWDATA, 32'h0);
    chk("rstm_haddr0", HADDR, 32'h0);
    seen = rsp_valid;
    repeat (4) begin tick(); seen |= rsp_valid; end
    chk("rstm_norsp", 32'(seen), 32'h0);
    do_cmd(1'b0, 2'd2, 32'h0, 32'h0, rd, er, lat, ha, hs, hw);
    chk("rstm_after_lat", 32'(lat), 32'd2);
    chk("rstm_after_data", rd, 32'hAB332211);

`ifdef AHB_MASTER_ERR_EN
    // Two-cycle error on the first of two pipelined reads
    err_req = 1'b1;
    cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h0; cmd_valid = 1'b1;
    tick();
    cmd_addr = 32'hA00;
    tick();
    err_req = 1'b0;
    cmd_valid = 1'b0;
    chk("err_ready_low", 32'(cmd_ready), 32'h0);
    chk("err_htrans_pre", 32'(HTRANS), 32'h2);
    tick();
    chk("err_htrans_idle", 32'(HTRANS), 32'h0);
    chk("err_norsp", 32'(rsp_valid), 32'h0);
    tick();
    chk("err_rsp1", {rsp_valid, rsp_err}, 32'h3);
    tick();
    chk("err_rsp2", {rsp_valid, rsp_err}, 32'h3);
    chk("err_rsp2_rdata", rsp_rdata, 32'h0);
    tick();
    chk("err_quiet", 32'(rsp_valid), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
